// File: rtl/uart_tx_sequencer.sv
// uart_tx_sequencer: turns debounced send-button presses into LOAD/READY/START strobe
// sequences, one UART frame each. Optional continuous send is enabled by TX_SEQ_AUTO_REPEAT_EN.
module uart_tx_sequencer #(
    parameter int FRAME_BITS = 10,
    parameter int GAP_CYCLES = 2,
    parameter int DEB_CYCLES = 4,
    parameter int PEND_MAX   = 3
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       send_btn,
    input  logic       auto_mode,
    output logic       load_data,
    output logic       b_ready,
    output logic       t_init,
    output logic       busy,
    output logic       frame_done,
    output logic [7:0] frames_sent,
    output logic       pend_ovf
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_READY = 3'd2,
        S_START = 3'd3,
        S_SHIFT = 3'd4,
        S_GAP   = 3'd5
    } state_t;

    localparam logic [7:0] DEB_LAST  = 8'(DEB_CYCLES - 1);
    localparam logic [7:0] BIT_LAST  = 8'(FRAME_BITS - 1);
    localparam logic [7:0] GAP_LAST  = (GAP_CYCLES == 0) ? 8'd0 : 8'(GAP_CYCLES - 1);
    localparam logic [2:0] PEND_FULL = 3'(PEND_MAX);

    state_t     state;
    state_t     state_next;
    logic       sync1, sync2, deb_level, deb_prev, req;
    logic [7:0] deb_cnt, bit_cnt, gap_cnt;
    logic [2:0] pend;
    logic       take, start_go, frame_end;

    // Synchronizer, debounce and rising-edge request (req is registered one cycle after the flip)
    always_ff @(posedge clk) begin
        if (!rstn) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            deb_level <= 1'b0;
            deb_prev  <= 1'b0;
            deb_cnt   <= 8'd0;
            req       <= 1'b0;
        end else begin
            sync1    <= send_btn;
            sync2    <= sync1;
            deb_prev <= deb_level;
            req      <= deb_level & ~deb_prev;
            if (sync2 == deb_level) begin
                deb_cnt <= 8'd0;
            end else if (deb_cnt == DEB_LAST) begin
                deb_level <= sync2;
                deb_cnt   <= 8'd0;
            end else begin
                deb_cnt <= deb_cnt + 8'd1;
            end
        end
    end

    assign take = (state == S_IDLE) && (pend != 3'd0);

`ifdef TX_SEQ_AUTO_REPEAT_EN
    assign start_go = take | ((state == S_IDLE) & auto_mode);
`else
    logic unused_auto;
    assign unused_auto = auto_mode;
    assign start_go    = take;
`endif

    always_ff @(posedge clk) begin
        if (!rstn) begin
            pend     <= 3'd0;
            pend_ovf <= 1'b0;
        end else begin
            case ({req, take})
                2'b10: begin
                    if (pend == PEND_FULL) pend_ovf <= 1'b1;
                    else                   pend     <= pend + 3'd1;
                end
                2'b01:   pend <= pend - 3'd1;
                default: pend <= pend;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start_go) state_next = S_LOAD;
            S_LOAD:  state_next = S_READY;
            S_READY: state_next = S_START;
            S_START: state_next = S_SHIFT;
            S_SHIFT: begin
                if (bit_cnt == BIT_LAST) state_next = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
            end
            S_GAP:   if (gap_cnt == GAP_LAST) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    assign frame_end = ((state == S_SHIFT) || (state == S_GAP)) && (state_next == S_IDLE);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state       <= S_IDLE;
            bit_cnt     <= 8'd0;
            gap_cnt     <= 8'd0;
            frame_done  <= 1'b0;
            frames_sent <= 8'd0;
        end else begin
            state      <= state_next;
            bit_cnt    <= (state == S_SHIFT) ? bit_cnt + 8'd1 : 8'd0;
            gap_cnt    <= (state == S_GAP) ? gap_cnt + 8'd1 : 8'd0;
            frame_done <= frame_end;
            if (frame_end) frames_sent <= frames_sent + 8'd1;
        end
    end

    assign load_data = (state == S_LOAD);
    assign b_ready   = (state == S_READY);
    assign t_init    = (state == S_START);
    assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Bench for uart_tx_sequencer: directed and randomized button scenarios against a
// timestamp/queue reference model; a second instance with GAP_CYCLES=0 covers the count wrap.
module tb_uart_tx_sequencer;
    localparam int F  = 10;
    localparam int G  = 2;
    localparam int D  = 4;
    localparam int PM = 3;
    localparam int N  = 1024;

    logic clk = 1'b0;
    logic rstn, send_btn, auto_mode;
    logic load_data, b_ready, t_init, busy, frame_done, pend_ovf;
    logic [7:0] frames_sent;
    logic g0_load_data, g0_b_ready, g0_t_init, g0_busy, g0_frame_done, g0_pend_ovf;
    logic [7:0] g0_frames_sent;

    always #5 clk = ~clk;

    uart_tx_sequencer dut (
        .clk(clk), .rstn(rstn), .send_btn(send_btn), .auto_mode(auto_mode),
        .load_data(load_data), .b_ready(b_ready), .t_init(t_init), .busy(busy),
        .frame_done(frame_done), .frames_sent(frames_sent), .pend_ovf(pend_ovf)
    );

    uart_tx_sequencer #(.GAP_CYCLES(0)) dut0 (
        .clk(clk), .rstn(rstn), .send_btn(send_btn), .auto_mode(auto_mode),
        .load_data(g0_load_data), .b_ready(g0_b_ready), .t_init(g0_t_init), .busy(g0_busy),
        .frame_done(g0_frame_done), .frames_sent(g0_frames_sent), .pend_ovf(g0_pend_ovf)
    );

    int   n_pass = 0;
    int   n_total = 0;
    logic btn_arr[N];
    logic auto_arr[N];
    logic arr_at[N];
    int   load_q[$], ready_q[$], init_q[$], done_q[$];
    int   busy_n, excl_n;
    int   exp_load[$];
    logic exp_ovf;

    task automatic clear_stim();
        for (int i = 0; i < N; i++) begin
            btn_arr[i]  = 1'b0;
            auto_arr[i] = 1'b0;
            arr_at[i]   = 1'b0;
        end
    endtask

    // A clean press first sampled at p can start a frame no earlier than p+D+4.
    task automatic add_press(input int p, input int h);
        for (int i = p; i < p + h; i++) btn_arr[i] = 1'b1;
        arr_at[p + D + 4] = 1'b1;
    endtask

    task automatic do_reset(input logic btn);
        rstn      = 1'b0;
        send_btn  = btn;
        auto_mode = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    // Interval t is the cycle following the t-th active edge after reset release.
    task automatic run_dut(input int t_len);
        load_q.delete(); ready_q.delete(); init_q.delete(); done_q.delete();
        busy_n = 0;
        excl_n = 0;
        for (int t = 0; t < t_len; t++) begin
            send_btn  = btn_arr[t];
            auto_mode = auto_arr[t];
            @(posedge clk);
            #1;
            if (load_data)  load_q.push_back(t);
            if (b_ready)    ready_q.push_back(t);
            if (t_init)     init_q.push_back(t);
            if (frame_done) done_q.push_back(t);
            if (busy) busy_n++;
            if (int'(load_data) + int'(b_ready) + int'(t_init) > 1) excl_n++;
        end
        send_btn  = 1'b0;
        auto_mode = 1'b0;
    endtask

    // Reference: a frame starts when the sequencer is free and work is queued; each frame
    // occupies 4+F+G cycles including the mandatory idle cycle. Queue changes land one
    // cycle before a request becomes startable.
    task automatic model_run(input int t_len);
        int  pend;
        int  free_at;
        int  pb;
        bit  ld, dec, go_auto;
        pend    = 0;
        free_at = 0;
        exp_ovf = 1'b0;
        exp_load.delete();
        for (int t = 0; t < t_len; t++) begin
            pb = pend;
            go_auto = 1'b0;
`ifdef TX_SEQ_AUTO_REPEAT_EN
            go_auto = auto_arr[t];
`endif
            ld  = (t >= free_at) && (pb > 0 || go_auto);
            dec = ld && (pb > 0);
            if (ld) begin
                exp_load.push_back(t);
                free_at = t + F + G + 4;
            end
            if (dec) pend = pb - 1;
            if (t + 1 < N && arr_at[t + 1]) begin
                if (dec)           pend = pb;
                else if (pb == PM) exp_ovf = 1'b1;
                else               pend = pb + 1;
            end
        end
    endtask

    task automatic test_reset();
        logic [13:0] outs;
        do_reset(1'b0);
        clear_stim();
        add_press(0, 4);
        add_press(8, 4);
        run_dut(30);
        n_total++;
        if (frames_sent !== 8'd1) $display("FAIL reset_pre_count: got %0d want 1", frames_sent);
        else n_pass++;
        n_total++;
        if (busy !== 1'b1) $display("FAIL reset_pre_busy: got %0b want 1", busy);
        else n_pass++;
        rstn     = 1'b0;
        send_btn = 1'b0;
        @(posedge clk);
        #1;
        outs = {load_data, b_ready, t_init, busy, frame_done, pend_ovf, frames_sent};
        n_total++;
        if (outs !== 14'd0) $display("FAIL reset_first_cycle: got %h want 0", outs);
        else n_pass++;
        repeat (2) @(posedge clk);
        #1;
        outs = {load_data, b_ready, t_init, busy, frame_done, pend_ovf, frames_sent};
        n_total++;
        if (outs !== 14'd0) $display("FAIL reset_held: got %h want 0", outs);
        else n_pass++;
        rstn = 1'b1;
        clear_stim();
        run_dut(40);
        n_total++;
        if (load_q.size() + init_q.size() + done_q.size() + busy_n !== 0)
            $display("FAIL reset_quiet: got %0d activity want 0", load_q.size() + init_q.size() + done_q.size() + busy_n);
        else n_pass++;
        n_total++;
        if (frames_sent !== 8'd0) $display("FAIL reset_count_after: got %0d want 0", frames_sent);
        else n_pass++;
    endtask

    task automatic test_reset_held_button();
        do_reset(1'b1);
        clear_stim();
        for (int i = 0; i < 30; i++) btn_arr[i] = 1'b1;
        run_dut(30);
        n_total++;
        if (load_q.size() !== 1 || load_q[0] !== 8)
            $display("FAIL held_after_reset: got %0d loads first %0d want 1 at 8", load_q.size(), (load_q.size() > 0) ? load_q[0] : -1);
        else n_pass++;
    endtask

    task automatic test_single_press();
        do_reset(1'b0);
        clear_stim();
        for (int i = 0; i < 20; i++) btn_arr[i] = 1'b1;
        run_dut(40);
        n_total++;
        if (load_q.size() !== 1 || load_q[0] !== 8)
            $display("FAIL single_load: got %0d loads first %0d want 1 at 8", load_q.size(), (load_q.size() > 0) ? load_q[0] : -1);
        else n_pass++;
        n_total++;
        if (ready_q.size() !== 1 || ready_q[0] !== 9)
            $display("FAIL single_ready: got %0d pulses first %0d want 1 at 9", ready_q.size(), (ready_q.size() > 0) ? ready_q[0] : -1);
        else n_pass++;
        n_total++;
        if (init_q.size() !== 1 || init_q[0] !== 10)
            $display("FAIL single_init: got %0d pulses first %0d want 1 at 10", init_q.size(), (init_q.size() > 0) ? init_q[0] : -1);
        else n_pass++;
        n_total++;
        if (done_q.size() !== 1 || done_q[0] !== 23)
            $display("FAIL single_done: got %0d pulses first %0d want 1 at 23", done_q.size(), (done_q.size() > 0) ? done_q[0] : -1);
        else n_pass++;
        n_total++;
        if (frames_sent !== 8'd1) $display("FAIL single_count: got %0d want 1", frames_sent);
        else n_pass++;
        n_total++;
        if (busy_n !== 15) $display("FAIL single_busy: got %0d want 15", busy_n);
        else n_pass++;
    endtask

    task automatic test_bounce();
        do_reset(1'b0);
        clear_stim();
        for (int i = 0; i < 16; i++) btn_arr[i] = ((i / 2) % 2 == 0);
        run_dut(60);
        n_total++;
        if (load_q.size() + ready_q.size() + init_q.size() !== 0)
            $display("FAIL bounce_strobes: got %0d want 0", load_q.size() + ready_q.size() + init_q.size());
        else n_pass++;
        n_total++;
        if (pend_ovf !== 1'b0) $display("FAIL bounce_ovf: got %0b want 0", pend_ovf);
        else n_pass++;
    endtask

    task automatic test_queue(input bit directed);
        int p, n, h, t_len, m;
        do_reset(1'b0);
        clear_stim();
        p = 0;
        if (directed) begin
            for (int k = 0; k < 7; k++) add_press(8 * k, 4);
            p = 56;
        end else begin
            p = $urandom_range(0, 5);
            n = $urandom_range(6, 12);
            for (int k = 0; k < n; k++) begin
                h = $urandom_range(4, 7);
                add_press(p, h);
                p = p + h + $urandom_range(4, 10);
            end
        end
        t_len = p + D + 4 + 16 * (PM + 2);
        model_run(t_len);
        run_dut(t_len);
        n_total++;
        if (load_q.size() !== exp_load.size())
            $display("FAIL queue_frames: got %0d want %0d", load_q.size(), exp_load.size());
        else n_pass++;
        m = (load_q.size() < exp_load.size()) ? load_q.size() : exp_load.size();
        for (int i = 0; i < m; i++) begin
            n_total++;
            if (load_q[i] !== exp_load[i]) $display("FAIL queue_load[%0d]: got %0d want %0d", i, load_q[i], exp_load[i]);
            else n_pass++;
            n_total++;
            if (i >= init_q.size() || init_q[i] !== exp_load[i] + 2)
                $display("FAIL queue_init[%0d]: got %0d want %0d", i, (i < init_q.size()) ? init_q[i] : -1, exp_load[i] + 2);
            else n_pass++;
            n_total++;
            if (i >= done_q.size() || done_q[i] !== exp_load[i] + 3 + F + G)
                $display("FAIL queue_done[%0d]: got %0d want %0d", i, (i < done_q.size()) ? done_q[i] : -1, exp_load[i] + 3 + F + G);
            else n_pass++;
        end
        n_total++;
        if (frames_sent !== 8'(exp_load.size())) $display("FAIL queue_count: got %0d want %0d", frames_sent, exp_load.size());
        else n_pass++;
        n_total++;
        if (pend_ovf !== exp_ovf) $display("FAIL queue_ovf: got %0b want %0b", pend_ovf, exp_ovf);
        else n_pass++;
        n_total++;
        if (busy_n !== exp_load.size() * (3 + F + G)) $display("FAIL queue_busy: got %0d want %0d", busy_n, exp_load.size() * (3 + F + G));
        else n_pass++;
        n_total++;
        if (excl_n !== 0) $display("FAIL queue_exclusive: got %0d overlaps want 0", excl_n);
        else n_pass++;
        if (directed) begin
            // Seven presses 8 cycles apart: the seventh lands on a full queue.
            n_total++;
            if (pend_ovf !== 1'b1 || load_q.size() !== 6)
                $display("FAIL burst_drop: got ovf %0b frames %0d want ovf 1 frames 6", pend_ovf, load_q.size());
            else n_pass++;
        end
    endtask

    task automatic test_auto();
        do_reset(1'b0);
        clear_stim();
        for (int i = 0; i < 60; i++) auto_arr[i] = 1'b1;
        run_dut(80);
`ifdef TX_SEQ_AUTO_REPEAT_EN
        n_total++;
        if (init_q.size() !== 4 || init_q[0] !== 2 || init_q[1] !== 18 || init_q[2] !== 34 || init_q[3] !== 50)
            $display("FAIL auto_init: got %0d pulses first %0d want 4 at 2,18,34,50", init_q.size(), (init_q.size() > 0) ? init_q[0] : -1);
        else n_pass++;
        n_total++;
        if (frames_sent !== 8'd4) $display("FAIL auto_count: got %0d want 4", frames_sent);
        else n_pass++;
`else
        n_total++;
        if (load_q.size() + ready_q.size() + init_q.size() !== 0)
            $display("FAIL auto_ignored: got %0d strobes want 0", load_q.size() + ready_q.size() + init_q.size());
        else n_pass++;
        n_total++;
        if (busy_n !== 0) $display("FAIL auto_busy: got %0d want 0", busy_n);
        else n_pass++;
`endif
    endtask

    task automatic test_wrap_gap0();
        int k, last, first, sp_err, fs_err, fs_at_256, t;
        do_reset(1'b0);
        k = 0; last = -1; first = -1; sp_err = 0; fs_err = 0; fs_at_256 = -1; t = 0;
        while (k < 256 && t < 256 * 14 + 200) begin
            send_btn = ((t % 8) < 4);
            @(posedge clk);
            #1;
            if (g0_load_data) begin
                if (first < 0) first = t;
                if (last >= 0 && t - last != 14) sp_err++;
                last = t;
            end
            if (g0_frame_done) begin
                k++;
                if (g0_frames_sent !== 8'(k % 256)) fs_err++;
                if (k == 256) fs_at_256 = int'(g0_frames_sent);
            end
            t++;
        end
        send_btn = 1'b0;
        n_total++;
        if (k !== 256) $display("FAIL wrap_budget: got %0d frames want 256", k);
        else n_pass++;
        n_total++;
        if (first !== 8) $display("FAIL wrap_first_load: got %0d want 8", first);
        else n_pass++;
        n_total++;
        if (sp_err !== 0) $display("FAIL wrap_period: got %0d bad spacings want 0", sp_err);
        else n_pass++;
        n_total++;
        if (fs_err !== 0) $display("FAIL wrap_count_track: got %0d errors want 0", fs_err);
        else n_pass++;
        n_total++;
        if (fs_at_256 !== 0) $display("FAIL wrap_to_zero: got %0d want 0", fs_at_256);
        else n_pass++;
    endtask

    initial begin
        rstn      = 1'b0;
        send_btn  = 1'b0;
        auto_mode = 1'b0;
        test_reset();
        test_reset_held_button();
        test_single_press();
        test_bounce();
        test_queue(1'b1);
        for (int r = 0; r < 4; r++) test_queue(1'b0);
        test_auto();
        test_wrap_gap0();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
